// File: rtl/cc_pkg.sv
// Shared constants and types for the program ROM loader: ROM geometry,
// region indices and the loader state encoding.
package cc_pkg;

  localparam int unsigned ROM_COUNT = 5;
  localparam int unsigned ROM_AW    = 13;
  localparam int unsigned CNT_W     = 17;
  localparam int unsigned IOCTL_AW  = 25;

  // Region index = ioctl_addr[15:13]; bit position in rom_we.
  localparam logic [2:0] ROM_1F = 3'd0;
  localparam logic [2:0] ROM_1H = 3'd1;
  localparam logic [2:0] ROM_1K = 3'd2;
  localparam logic [2:0] ROM_1L = 3'd3;
  localparam logic [2:0] ROM_1N = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWrite,
    StDone
  } loader_state_e;

endpackage

// File: rtl/rom_region_decode.sv
// Combinational decode of a download byte offset into a one-hot ROM select
// and an in-range flag (offset below the image length and inside a real ROM).
module rom_region_decode
  import cc_pkg::*;
#(
  parameter logic [CNT_W-1:0] ROM_BYTES = 17'h0A000
) (
  input  logic [IOCTL_AW-1:0]  addr,
  output logic [ROM_COUNT-1:0] sel,
  output logic                 in_range
);

  logic [IOCTL_AW-1-ROM_AW:0] region;

  always_comb begin
    region   = addr[IOCTL_AW-1:ROM_AW];
    in_range = (addr < {{(IOCTL_AW-CNT_W){1'b0}}, ROM_BYTES}) &&
               (region < (IOCTL_AW-ROM_AW)'(ROM_COUNT));
    sel      = '0;
    if (in_range) begin
      unique case (region[2:0])
        ROM_1F:  sel[ROM_1F] = 1'b1;
        ROM_1H:  sel[ROM_1H] = 1'b1;
        ROM_1K:  sel[ROM_1K] = 1'b1;
        ROM_1L:  sel[ROM_1L] = 1'b1;
        ROM_1N:  sel[ROM_1N] = 1'b1;
        default: sel = '0;
      endcase
    end
  end

endmodule

// File: rtl/program_rom_loader.sv
// Streams an ioctl download image into five 8 KiB program ROMs, one byte per
// two cycles. Optional image checksum when PROGRAM_ROM_CHECKSUM_EN is defined.
module program_rom_loader
  import cc_pkg::*;
#(
  parameter logic [7:0]       LOAD_INDEX   = 8'd0,
  parameter logic [CNT_W-1:0] ROM_BYTES    = 17'h0A000
`ifdef PROGRAM_ROM_CHECKSUM_EN
  ,
  parameter logic [15:0]      EXPECTED_SUM = 16'h0000
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [IOCTL_AW-1:0]  ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  output logic                 ioctl_wait,
  output logic [ROM_COUNT-1:0] rom_we,
  output logic [ROM_AW-1:0]    rom_addr,
  output logic [7:0]           rom_data,
  output logic                 rom_ready,
  output logic                 load_error
`ifdef PROGRAM_ROM_CHECKSUM_EN
  ,
  output logic [15:0]          checksum
`endif
);

  loader_state_e        state_q, state_d;
  logic [ROM_AW-1:0]    rom_addr_q, rom_addr_d;
  logic [7:0]           rom_data_q, rom_data_d;
  logic [ROM_COUNT-1:0] sel_q, sel_d;
  logic                 in_range_q, in_range_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 drop_q, drop_d;
  logic                 ready_q, ready_d;
  logic                 error_q, error_d;
`ifdef PROGRAM_ROM_CHECKSUM_EN
  logic [15:0]          sum_q, sum_d;
`endif

  logic                 active;
  logic                 start;
  logic                 finish;
  logic                 good;
  logic [ROM_COUNT-1:0] dec_sel;
  logic                 dec_in_range;

  rom_region_decode #(
    .ROM_BYTES (ROM_BYTES)
  ) u_decode (
    .addr     (ioctl_addr),
    .sel      (dec_sel),
    .in_range (dec_in_range)
  );

  always_comb begin
    active     = ioctl_download && (ioctl_index == LOAD_INDEX);
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    sel_d      = sel_q;
    in_range_d = in_range_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    ready_d    = ready_q;
    error_d    = error_q;
    start      = 1'b0;
    finish     = 1'b0;
    good       = 1'b0;
`ifdef PROGRAM_ROM_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (active) begin
          state_d = StLoad;
          start   = 1'b1;
        end
      end
      StLoad: begin
        if (!active) begin
          state_d = StDone;
          finish  = 1'b1;
        end else if (ioctl_wr) begin
          rom_addr_d = ioctl_addr[ROM_AW-1:0];
          rom_data_d = ioctl_dout;
          sel_d      = dec_sel;
          in_range_d = dec_in_range;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        if (!in_range_q) ovf_d = 1'b1;
        // A strobe here violates the wait handshake; the byte is lost.
        if (ioctl_wr) drop_d = 1'b1;
`ifdef PROGRAM_ROM_CHECKSUM_EN
        if (in_range_q) sum_d = sum_q + 16'(rom_data_q);
`endif
        if (active) begin
          state_d = StLoad;
        end else begin
          state_d = StDone;
          finish  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      count_d = '0;
      ovf_d   = 1'b0;
      drop_d  = 1'b0;
      ready_d = 1'b0;
      error_d = 1'b0;
`ifdef PROGRAM_ROM_CHECKSUM_EN
      sum_d   = '0;
`endif
    end

    // Evaluated on next-state values so a write finishing this cycle counts.
    good = (count_d == ROM_BYTES) && !ovf_d && !drop_d;
`ifdef PROGRAM_ROM_CHECKSUM_EN
    good = good && ((EXPECTED_SUM == 16'h0000) || (sum_d == EXPECTED_SUM));
`endif
    if (finish) begin
      ready_d = good;
      error_d = !good;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      sel_q      <= '0;
      in_range_q <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
`ifdef PROGRAM_ROM_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      sel_q      <= sel_d;
      in_range_q <= in_range_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
`ifdef PROGRAM_ROM_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Reset gates the write strobe in the same cycle it is raised.
  always_comb begin
    ioctl_wait = (state_q == StWrite) && !reset;
    rom_we     = ioctl_wait ? sel_q : '0;
    rom_addr   = rom_addr_q;
    rom_data   = rom_data_q;
    rom_ready  = ready_q;
    load_error = error_q;
`ifdef PROGRAM_ROM_CHECKSUM_EN
    checksum   = sum_q;
`endif
  end

endmodule
